sr_reg_bank: RTL and testbench

Parametrised, clocked successor to the single-bit SR latch: a bank of NUM_CH independent SR flip-flops in one clock domain. Each channel's set/reset inputs pass through an optional synchronizer. A run-time mode selects how simultaneous set+reset is resolved: set-dominant, reset-dominant, hold, or toggle. Simultaneous set+reset events are captured as per-channel sticky flags and a saturating event counter. Used wherever the design needs asynchronous-origin status flags captured cleanly into synchronous logic.

---
 rtl/sr_pkg.sv | 31 +++
 rtl/sr_sync.sv | 32 +++
 rtl/sr_reg_bank.sv | 76 +++++++
 tb/tb_sr_reg_bank.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and the per-channel next-state rule for the SR register bank.
// The same rule is used by the RTL and any reference model.
package sr_pkg;

  typedef enum logic [1:0] {
    SR_SET_DOM = 2'd0,
    SR_RST_DOM = 2'd1,
    SR_HOLD    = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_mode_e mode);
    logic nq;
    nq = q;
    if (s && r) begin
      case (mode)
        SR_SET_DOM: nq = 1'b1;
        SR_RST_DOM: nq = 1'b0;
        SR_HOLD:    nq = q;
        default:    nq = ~q;
      endcase
    end else if (s) begin
      nq = 1'b1;
    end else if (r) begin
      nq = 1'b0;
    end
    return nq;
  endfunction

endpackage

// File: rtl/sr_sync.sv
// Multi-stage flop synchronizer with synchronous active-low clear.
// STAGES=0 collapses to a wire so the caller sees the raw input.
module sr_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_flops
      logic [WIDTH-1:0] stg [STAGES];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < STAGES; k++) stg[k] <= '0;
        end else begin
          stg[0] <= din;
          for (int k = 1; k < STAGES; k++) stg[k] <= stg[k-1];
        end
      end

      assign dout = stg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of clocked SR flip-flops with selectable set&reset resolution,
// sticky per-channel conflict flags and a saturating conflict counter.
module sr_reg_bank
  import sr_pkg::*;
#(
  parameter int                NUM_CH      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '0,
  parameter int                CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] set,
  input  logic [NUM_CH-1:0] reset,
  input  sr_mode_e          mode,
  input  logic              clr_conflict,
  output logic [NUM_CH-1:0] q,
  output logic [NUM_CH-1:0] q_not,
  output logic [NUM_CH-1:0] conflict,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [NUM_CH-1:0] s_set;
  logic [NUM_CH-1:0] s_reset;
  logic [NUM_CH-1:0] both;
  logic              any_both;

  sr_sync #(.WIDTH(NUM_CH), .STAGES(SYNC_STAGES)) u_sync_set (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (set),
    .dout  (s_set)
  );

  sr_sync #(.WIDTH(NUM_CH), .STAGES(SYNC_STAGES)) u_sync_reset (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (reset),
    .dout  (s_reset)
  );

  assign both     = s_set & s_reset;
  assign any_both = |both;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic q_ch;

      always_ff @(posedge clk) begin
        if (!rst_n) q_ch <= RESET_VAL[i];
        else        q_ch <= sr_next(q_ch, s_set[i], s_reset[i], mode);
      end

      assign q[i] = q_ch;
    end
  endgenerate

  // Inverter straight off the state flop keeps q_not complementary in every cycle.
  assign q_not = ~q;

  // A conflict on the clearing edge survives the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict     <= '0;
      conflict_cnt <= '0;
    end else begin
      conflict <= (clr_conflict ? '0 : conflict) | both;
      if (clr_conflict) begin
        conflict_cnt <= any_both ? CNT_W'(1) : '0;
      end else if (any_both && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sr_reg_bank.sv
// Scoreboard bench for sr_reg_bank: a behavioural model predicts every cycle,
// and each scenario task adds its own directed checks.
module tb_sr_reg_bank;
  import sr_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] set;
  logic [7:0] reset;
  sr_mode_e   mode;
  logic       clr_conflict;
  logic [7:0] q;
  logic [7:0] q_not;
  logic [7:0] conflict;
  logic [3:0] conflict_cnt;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] qn;
    logic [7:0] conf;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  // behavioural model state
  logic [7:0] m_q, m_s1, m_s2, m_r1, m_r2, m_conf;
  logic [3:0] m_cnt;

  sr_reg_bank #(
    .NUM_CH      (8),
    .SYNC_STAGES (2),
    .RESET_VAL   (8'hA5),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .set          (set),
    .reset        (reset),
    .mode         (mode),
    .clr_conflict (clr_conflict),
    .q            (q),
    .q_not        (q_not),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Predict the outcome of the coming edge, queue it, then advance past the edge.
  task automatic tick();
    logic [7:0] ss, sr, bb;
    if (!rst_n) begin
      m_q = 8'hA5; m_s1 = '0; m_s2 = '0; m_r1 = '0; m_r2 = '0;
      m_conf = '0; m_cnt = '0;
    end else begin
      ss = m_s2; sr = m_r2; bb = ss & sr;
      for (int i = 0; i < 8; i++) begin
        if (bb[i]) begin
          if (mode == SR_SET_DOM)      m_q[i] = 1'b1;
          else if (mode == SR_RST_DOM) m_q[i] = 1'b0;
          else if (mode == SR_TOGGLE)  m_q[i] = ~m_q[i];
        end else if (ss[i]) m_q[i] = 1'b1;
        else if (sr[i])     m_q[i] = 1'b0;
      end
      m_conf = (clr_conflict ? 8'h00 : m_conf) | bb;
      if (clr_conflict)             m_cnt = (bb != 0) ? 4'd1 : 4'd0;
      else if (bb != 0 && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      m_s2 = m_s1; m_s1 = set; m_r2 = m_r1; m_r1 = reset;
    end
    sb.push_back({m_q, ~m_q, m_conf, m_cnt});
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if ({q, q_not, conflict, conflict_cnt} !== e) begin
          n_err++;
          $display("FAIL scoreboard t=%0t got q=%h qn=%h conf=%h cnt=%h want q=%h qn=%h conf=%h cnt=%h",
                   $time, q, q_not, conflict, conflict_cnt, e.q, e.qn, e.conf, e.cnt);
        end
      end
    end
  end

  task automatic test_reset();
    set = 8'hFF; reset = 8'h00; rst_n = 1'b0;
    tick(); tick();
    n_vec++;
    if (q !== 8'hA5 || q_not !== 8'h5A || conflict !== 8'h00 || conflict_cnt !== 4'h0) begin
      n_err++;
      $display("FAIL reset_state got q=%h qn=%h conf=%h cnt=%h want a5/5a/00/0",
               q, q_not, conflict, conflict_cnt);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_vec++;
      if (q !== ((k < 3) ? 8'hA5 : 8'hFF)) begin
        n_err++;
        $display("FAIL reset_release edge=%0d got q=%h want %h", k, q, (k < 3) ? 8'hA5 : 8'hFF);
      end
    end
    set = 8'h00;
    tick();
  endtask

  // Drive all-reset for one cycle and let it settle so every q is 0.
  task automatic clear_q();
    set = 8'h00; reset = 8'hFF;
    tick();
    reset = 8'h00;
    tick(); tick(); tick();
  endtask

  task automatic test_latency();
    clear_q();
    for (int ph = 0; ph < 2; ph++) begin
      set   = (ph == 0) ? 8'h01 : 8'h00;
      reset = (ph == 0) ? 8'h00 : 8'h01;
      for (int k = 1; k <= 5; k++) begin
        tick();
        set = 8'h00; reset = 8'h00;
        n_vec++;
        if (q[0] !== ((k >= 3) ? (ph == 0) : (ph != 0)) || q_not[0] !== ~q[0]) begin
          n_err++;
          $display("FAIL latency ph=%0d edge=%0d got q0=%b qn0=%b want q0=%b",
                   ph, k, q[0], q_not[0], (k >= 3) ? (ph == 0) : (ph != 0));
        end
      end
    end
  endtask

  task automatic test_modes();
    logic [3:0] want [4];
    want[0] = 4'b1111; want[1] = 4'b0000; want[2] = 4'b0000; want[3] = 4'b1010;
    for (int m = 0; m < 4; m++) begin
      clear_q();
      mode = sr_mode_e'(m);
      for (int k = 1; k <= 6; k++) begin
        set   = (k <= 4) ? 8'h01 : 8'h00;
        reset = (k <= 4) ? 8'h01 : 8'h00;
        tick();
        if (k >= 3) begin
          n_vec++;
          if (q[0] !== want[m][6-k]) begin
            n_err++;
            $display("FAIL mode=%0d edge=%0d got q0=%b want %b", m, k, q[0], want[m][6-k]);
          end
        end
      end
    end
  endtask

  task automatic test_conflict();
    set = 8'h00; reset = 8'h00; mode = SR_SET_DOM;
    clr_conflict = 1'b1; tick(); clr_conflict = 1'b0;
    n_vec++;
    if (conflict !== 8'h00 || conflict_cnt !== 4'h0) begin
      n_err++;
      $display("FAIL conflict_clr0 got conf=%h cnt=%h want 00/0", conflict, conflict_cnt);
    end
    set = 8'h81; reset = 8'h81;
    tick(); tick(); tick();
    set = 8'h00; reset = 8'h00;
    tick(); tick();
    n_vec++;
    if (conflict !== 8'h81 || conflict_cnt !== 4'h3) begin
      n_err++;
      $display("FAIL conflict_three got conf=%h cnt=%h want 81/3", conflict, conflict_cnt);
    end
    clr_conflict = 1'b1; tick(); clr_conflict = 1'b0;
    n_vec++;
    if (conflict !== 8'h00 || conflict_cnt !== 4'h0) begin
      n_err++;
      $display("FAIL conflict_clr got conf=%h cnt=%h want 00/0", conflict, conflict_cnt);
    end
    set = 8'h81; reset = 8'h81; tick();
    set = 8'h00; reset = 8'h00; tick();
    clr_conflict = 1'b1; tick(); clr_conflict = 1'b0;
    n_vec++;
    if (conflict !== 8'h81 || conflict_cnt !== 4'h1) begin
      n_err++;
      $display("FAIL conflict_coincident got conf=%h cnt=%h want 81/1", conflict, conflict_cnt);
    end
  endtask

  task automatic test_saturation();
    mode = SR_HOLD;
    clr_conflict = 1'b1; tick(); clr_conflict = 1'b0;
    set = 8'hFF; reset = 8'hFF;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 16 || k == 17 || k == 20) begin
        n_vec++;
        if (conflict_cnt !== ((k == 16) ? 4'hE : 4'hF)) begin
          n_err++;
          $display("FAIL saturation tick=%0d got cnt=%h want %h", k, conflict_cnt,
                   (k == 16) ? 4'hE : 4'hF);
        end
      end
    end
    set = 8'h00; reset = 8'h00;
    tick(); tick();
  endtask

  task automatic test_mid_reset();
    mode = SR_SET_DOM;
    clear_q();
    set = 8'h08; tick();
    rst_n = 1'b0; tick();
    n_vec++;
    if (q !== 8'hA5) begin
      n_err++;
      $display("FAIL mid_reset_state got q=%h want a5", q);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_vec++;
      if (q[3] !== (k == 3)) begin
        n_err++;
        $display("FAIL mid_reset_held edge=%0d got q3=%b want %b", k, q[3], (k == 3));
      end
    end
    rst_n = 1'b0; set = 8'h00; tick();
    rst_n = 1'b1; set = 8'h08; tick();
    set = 8'h00; rst_n = 1'b0; tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    n_vec++;
    if (q !== 8'hA5) begin
      n_err++;
      $display("FAIL mid_reset_discard got q=%h want a5", q);
    end
  endtask

  initial begin
    rst_n = 1'b0; set = 8'h00; reset = 8'h00;
    mode = SR_SET_DOM; clr_conflict = 1'b0;
    test_reset();
    test_latency();
    test_modes();
    test_conflict();
    test_saturation();
    test_mid_reset();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
